// File: rtl/jvm_micro_sequencer.sv
// jvm_micro_sequencer: walks an external microcode table per JVM opcode and emits instruction ids with handshake
module jvm_micro_sequencer #(
  parameter int OP_W      = 8,
  parameter int ADR_W     = 9,
  parameter int INST_W    = 7,
  parameter int MAX_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic              flush,
  output logic [ADR_W-1:0]  tbl_adr,
  input  logic [INST_W-1:0] tbl_inst,
  input  logic [ADR_W-1:0]  tbl_next,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_id,
  output logic              inst_last,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        step_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  state_t state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [7:0] step_q, step_d, step_inc;
  logic [1:0] code_q, code_d;
  logic bad, hs;
  // An all-ones id marks an unmapped table entry and suppresses the emit.
  assign bad        = state_q == RUN && &tbl_inst;
  assign op_ready   = state_q == IDLE;
  assign inst_valid = state_q == RUN && !bad;
  assign inst_last  = state_q == RUN && tbl_next == '0;
  assign inst_id    = tbl_inst;
  assign hs         = inst_valid && inst_ready;
  assign step_inc   = step_q + 8'd1;
  assign tbl_adr    = adr_q;
  assign step_cnt   = step_q;
  assign err        = state_q == ERR;
  assign err_code   = code_q;
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    step_d  = step_q;
    code_d  = code_q;
    if (flush) begin
      state_d = IDLE;
      step_d  = '0;
      code_d  = '0;
    end else if (state_q == IDLE && op_valid) begin
      state_d = RUN;
      adr_d   = {{(ADR_W-OP_W){1'b0}}, opcode};
      step_d  = '0;
    end else if (bad) begin
      state_d = ERR;
      code_d  = 2'b01;
    end else if (hs) begin
      step_d = step_inc;
      if (inst_last) state_d = IDLE;
      else if (step_inc == 8'(MAX_STEPS)) begin
        state_d = ERR;
        code_d  = 2'b10;
      end else adr_d = tbl_next;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      step_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      step_q  <= step_d;
      code_q  <= code_d;
    end
  end
endmodule

// File: tb/tb_jvm_micro_sequencer.sv
// tb_jvm_micro_sequencer: directed scenarios with a scoreboard queue checked by an independent handshake monitor
module tb_jvm_micro_sequencer;
  logic clk = 0, rst = 1, op_valid = 0, flush = 0, inst_ready = 0;
  logic [7:0] opcode = '0;
  logic [8:0] tbl_adr, tbl_next;
  logic [6:0] tbl_inst, inst_id;
  logic op_ready, inst_valid, inst_last, err;
  logic [1:0] err_code;
  logic [7:0] step_cnt;
  logic [6:0] ti [512];
  logic [8:0] tn [512];
  logic [7:0] exp_q [$];
  int checks = 0, errors = 0;

  jvm_micro_sequencer #(.OP_W(8), .ADR_W(9), .INST_W(7), .MAX_STEPS(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .flush(flush), .tbl_adr(tbl_adr), .tbl_inst(tbl_inst), .tbl_next(tbl_next),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_id(inst_id),
    .inst_last(inst_last), .err(err), .err_code(err_code), .step_cnt(step_cnt)
  );

  assign tbl_inst = ti[tbl_adr];
  assign tbl_next = tn[tbl_adr];
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && !flush && inst_valid && inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL emit unexpected id=%0d last=%0d", inst_id, inst_last);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({inst_id, inst_last} !== e) begin
          errors++;
          $display("FAIL emit got id=%0d last=%0d want id=%0d last=%0d", inst_id, inst_last, e[7:1], e[0]);
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [7:0] op);
    op_valid = 1;
    opcode = op;
    tick();
    op_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ti[i] = '0;
      tn[i] = '0;
    end
    ti[9'h00B] = 7'd11; tn[9'h00B] = 9'h100;
    ti[9'h100] = 7'd10; tn[9'h100] = 9'h000;
    ti[9'h020] = 7'h7F; tn[9'h020] = 9'h021;
    ti[9'h030] = 7'd5;  tn[9'h030] = 9'h030;
    ti[9'h040] = 7'd1;  tn[9'h040] = 9'h041;
    ti[9'h041] = 7'd2;  tn[9'h041] = 9'h042;
    ti[9'h042] = 7'd3;  tn[9'h042] = 9'h000;
    ti[9'h000] = 7'd7;  tn[9'h000] = 9'h000;
    tick(); tick();
    chk("rst_op_ready", op_ready, 1);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_last", inst_last, 0);
    chk("rst_tbl_adr", tbl_adr, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    rst = 0;
    tick();
    // two-id sequence under continuous ready
    inst_ready = 1;
    exp_q.push_back({7'd11, 1'b0});
    exp_q.push_back({7'd10, 1'b1});
    start(8'h0B);
    chk("seq_first_valid", inst_valid, 1);
    chk("seq_op_ready_low", op_ready, 0);
    chk("seq_adr_opcode", tbl_adr, 9'h00B);
    tick();
    chk("seq_adr_next", tbl_adr, 9'h100);
    tick();
    chk("seq_step_cnt", step_cnt, 2);
    chk("seq_op_ready_back", op_ready, 1);
    chk("seq_idle_valid", inst_valid, 0);
    // same sequence with back-pressure
    inst_ready = 0;
    exp_q.push_back({7'd11, 1'b0});
    exp_q.push_back({7'd10, 1'b1});
    start(8'h0B);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", inst_valid, 1);
      chk("stall_id", inst_id, 11);
      chk("stall_last", inst_last, 0);
      chk("stall_adr", tbl_adr, 9'h00B);
      tick();
    end
    inst_ready = 1;
    tick(); tick();
    chk("stall_step_cnt", step_cnt, 2);
    chk("stall_op_ready", op_ready, 1);
    // unmapped id at the opcode address
    start(8'h20);
    chk("unmap_no_valid", inst_valid, 0);
    op_valid = 1;
    tick();
    chk("unmap_err", err, 1);
    chk("unmap_err_code", err_code, 1);
    chk("unmap_op_ready", op_ready, 0);
    tick();
    chk("unmap_hold_err", err, 1);
    chk("unmap_hold_op_ready", op_ready, 0);
    flush = 1;
    tick();
    flush = 0;
    op_valid = 0;
    chk("flush_err", err, 0);
    chk("flush_err_code", err_code, 0);
    chk("flush_op_ready", op_ready, 1);
    // self loop hits the step limit of 4
    for (int i = 0; i < 4; i++) exp_q.push_back({7'd5, 1'b0});
    start(8'h30);
    repeat (4) tick();
    chk("limit_err", err, 1);
    chk("limit_err_code", err_code, 2);
    chk("limit_step_cnt", step_cnt, 4);
    chk("limit_valid", inst_valid, 0);
    chk("limit_adr", tbl_adr, 9'h030);
    flush = 1;
    tick();
    flush = 0;
    // flush in the second cycle of a three-id sequence
    exp_q.push_back({7'd1, 1'b0});
    start(8'h40);
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("mflush_step_cnt", step_cnt, 0);
    chk("mflush_op_ready", op_ready, 1);
    chk("mflush_valid", inst_valid, 0);
    // opcode zero starts at address 0
    exp_q.push_back({7'd7, 1'b1});
    start(8'h00);
    chk("op0_adr", tbl_adr, 0);
    chk("op0_valid", inst_valid, 1);
    tick();
    chk("op0_step_cnt", step_cnt, 1);
    // reset beats flush and op_valid mid-sequence
    exp_q.push_back({7'd1, 1'b0});
    start(8'h40);
    tick();
    rst = 1; flush = 1; op_valid = 1; opcode = 8'h0B;
    tick();
    chk("mrst_tbl_adr", tbl_adr, 0);
    chk("mrst_step_cnt", step_cnt, 0);
    chk("mrst_err", err, 0);
    chk("mrst_err_code", err_code, 0);
    chk("mrst_valid", inst_valid, 0);
    chk("mrst_last", inst_last, 0);
    chk("mrst_op_ready", op_ready, 1);
    rst = 0; flush = 0; op_valid = 0;
    tick();
    chk("mrst_still_idle", op_ready, 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
